clint_dbus_arbiter: RTL
=======================

Name: clint_dbus_arbiter

Overview:
- Two-requester arbiter that shares the single CLINT register port (mtime/mtimecmp) between the core dbus (requester 0) and the debug module (requester 1).
- Latches one requester's command, drives it to the CLINT slave port and waits for the CLINT ack, then returns ack/r_data to the granted requester.
- Round-robin fairness on contention.
- Bounded-latency timeout so a missing slave ack cannot hang either master.

Parameters:
- ADDR_W, 8: width of the CLINT register address offset.
- DATA_W, 32: width of write and read data.
- TIMEOUT, 16: cycles in BUSY without m_ack before an error response. Legal range is 2 to 255.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset, synchronous and active-high.
- s_req_i  in  2  per-requester request; bit i belongs to requester i. Held until s_ack_o[i].
- s_sel_i  in  2  per-requester CLINT select from the address decoder. A request is valid only when s_req_i[i] and s_sel_i[i] are both high.
- s0_w_en_i, s1_w_en_i  in  1  write enable for requester 0 / 1.
- s0_addr_i, s1_addr_i  in  ADDR_W  register offset for requester 0 / 1.
- s0_w_data_i, s1_w_data_i  in  DATA_W  write data for requester 0 / 1.
- s_ack_o  out  2  one-cycle ack to requester i.
- s_err_o  out  1  high together with s_ack_o when the response is a timeout.
- s_r_data_o  out  DATA_W  read data returned to the acked requester.
- m_req_o  out  1  request to CLINT; also drives clint_sel.
- m_w_en_o  out  1  latched write enable to CLINT.
- m_addr_o  out  ADDR_W  latched address to CLINT.
- m_w_data_o  out  DATA_W  latched write data to CLINT.
- m_ack_i  in  1  CLINT ack; registered in CLINT, high for one cycle.
- m_r_data_i  in  DATA_W  CLINT read data, valid with m_ack_i.

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0.
  - last_grant=1, so requester 0 wins the first contention.
  - Timeout counter 0.
  - Reset mid-transaction abandons the transaction: no ack is issued and any later m_ack is ignored.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - valid_i = s_req_i[i] & s_sel_i[i].
  - If only one requester is valid, grant it.
  - If both are valid, grant ~last_grant.
  - On a grant: latch that requester's w_en/addr/w_data into the m_* registers, set m_req_o=1, clear the counter, go to BUSY.
  - With no valid request, stay in IDLE with m_req_o=0.
- BUSY:
  - m_req_o and the m_* fields are held stable. Requester inputs are ignored, including a changed addr.
  - The counter increments each cycle.
  - If m_ack_i=1: capture m_r_data_i (read) or 0 (write) into s_r_data_o, set s_ack_o[grant]=1, s_err_o=0, m_req_o=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: set s_r_data_o=0, s_ack_o[grant]=1, s_err_o=1, m_req_o=0, go to RESP.
  - If m_ack_i and the timeout coincide, m_ack_i wins and s_err_o=0.
- RESP:
  - s_ack_o and s_err_o are visible for exactly this one cycle.
  - last_grant is updated to grant.
  - Next state is IDLE, where s_ack_o, s_err_o and s_r_data_o are cleared.
  - The requester must drop s_req_i in the cycle after ack. The IDLE cycle ensures CLINT also sees m_req low for at least one cycle, so it never double-writes.
- m_ack_i outside BUSY (stale or late after a timeout) is ignored.
- Nominal latency:
  - Request valid in IDLE at cycle 0.
  - m_req_o high at cycle 1.
  - CLINT ack at cycle 2.
  - s_ack_o at cycle 3.
  - Throughput is one transaction per 4 cycles.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. A lone requester may be granted back-to-back.
- Writes: s_r_data_o=0.
- No reordering; at most one outstanding transaction.

Test Plan:
- Requester 0 reads offset 0x0 with CLINT returning 0x0000_1234 -> m_req_o high at cycle 1 with m_addr_o=0x0 and m_w_en_o=0; s_ack_o=2'b01, s_r_data_o=0x0000_1234, s_err_o=0 at cycle 3; s_ack_o=0 at cycle 4.
- Both requesters request in the same cycle after reset (r0 reads 0x8, r1 writes 0xC with 0xAABB_CCDD) -> r0 is served first (ack at cycle 3); then m_addr_o=0xC, m_w_en_o=1, m_w_data_o=0xAABB_CCDD; r1 is acked 4 cycles later with s_r_data_o=0.
- Both hold requests continuously for 6 transactions -> grant order 0,1,0,1,0,1; m_req_o low for at least 1 cycle between transactions.
- Requester 1 changes s1_addr_i from 0x4 to 0xC while in BUSY -> m_addr_o stays 0x4 until RESP.
- TIMEOUT=16 with CLINT never acking -> s_ack_o=2'b01 and s_err_o=1 with s_r_data_o=0 exactly 16 cycles after m_req_o rises; an m_ack_i injected 2 cycles later produces no s_ack_o.
- rst asserted for one cycle during BUSY -> next cycle all outputs 0 and state IDLE, no s_ack_o; then simultaneous requests grant requester 0 first.

Source files
------------

// File: rtl/clint_dbus_arbiter_if.sv
// Bus bundle between the two CLINT requesters, the arbiter and the CLINT port.
// The slave modport is the arbiter's view; master is the surrounding fabric
// (core dbus, debug module and the CLINT register block).
interface clint_dbus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    // requester side
    logic [1:0]        s_req_i;
    logic [1:0]        s_sel_i;
    logic              s0_w_en_i;
    logic              s1_w_en_i;
    logic [ADDR_W-1:0] s0_addr_i;
    logic [ADDR_W-1:0] s1_addr_i;
    logic [DATA_W-1:0] s0_w_data_i;
    logic [DATA_W-1:0] s1_w_data_i;
    logic [1:0]        s_ack_o;
    logic              s_err_o;
    logic [DATA_W-1:0] s_r_data_o;

    // CLINT side
    logic              m_req_o;
    logic              m_w_en_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_w_data_o;
    logic              m_ack_i;
    logic [DATA_W-1:0] m_r_data_i;

    modport slave (
        input  s_req_i, s_sel_i,
        input  s0_w_en_i, s1_w_en_i, s0_addr_i, s1_addr_i, s0_w_data_i, s1_w_data_i,
        output s_ack_o, s_err_o, s_r_data_o,
        output m_req_o, m_w_en_o, m_addr_o, m_w_data_o,
        input  m_ack_i, m_r_data_i
    );

    modport master (
        output s_req_i, s_sel_i,
        output s0_w_en_i, s1_w_en_i, s0_addr_i, s1_addr_i, s0_w_data_i, s1_w_data_i,
        input  s_ack_o, s_err_o, s_r_data_o,
        input  m_req_o, m_w_en_o, m_addr_o, m_w_data_o,
        output m_ack_i, m_r_data_i
    );
endinterface

// File: rtl/clint_dbus_arbiter.sv
// Shares the single CLINT register port between the core dbus (requester 0)
// and the debug module (requester 1). One outstanding transaction, round-robin
// on contention, and a timeout so a silent CLINT cannot hang either master.
module clint_dbus_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    clint_dbus_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_w_en_q, m_w_en_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_w_data_q, m_w_data_d;
    logic [1:0]        s_ack_q, s_ack_d;
    logic              s_err_q, s_err_d;
    logic [DATA_W-1:0] s_r_data_q, s_r_data_d;

    logic [1:0]        valid;
    logic              pick;
    logic              timeout_hit;

    // A request only counts when the address decoder selected the CLINT
    assign valid       = bus.s_req_i & bus.s_sel_i;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            m_req_q      <= 1'b0;
            m_w_en_q     <= 1'b0;
            m_addr_q     <= '0;
            m_w_data_q   <= '0;
            s_ack_q      <= 2'b00;
            s_err_q      <= 1'b0;
            s_r_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            m_w_en_q     <= m_w_en_d;
            m_addr_q     <= m_addr_d;
            m_w_data_q   <= m_w_data_d;
            s_ack_q      <= s_ack_d;
            s_err_q      <= s_err_d;
            s_r_data_q   <= s_r_data_d;
        end
    end

    // Next-state and next-output logic for IDLE -> BUSY -> RESP -> IDLE
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        m_w_en_d     = m_w_en_q;
        m_addr_d     = m_addr_q;
        m_w_data_d   = m_w_data_q;
        s_ack_d      = s_ack_q;
        s_err_d      = s_err_q;
        s_r_data_d   = s_r_data_q;
        pick         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_ack_d    = 2'b00;
                s_err_d    = 1'b0;
                s_r_data_d = '0;
                m_req_d    = 1'b0;
                if (valid != 2'b00) begin
                    // On contention the requester not served last time wins
                    pick       = (valid == 2'b11) ? ~last_grant_q : valid[1];
                    grant_d    = pick;
                    m_w_en_d   = pick ? bus.s1_w_en_i   : bus.s0_w_en_i;
                    m_addr_d   = pick ? bus.s1_addr_i   : bus.s0_addr_i;
                    m_w_data_d = pick ? bus.s1_w_data_i : bus.s0_w_data_i;
                    m_req_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real ack takes priority over a timeout in the same cycle
                if (bus.m_ack_i) begin
                    s_r_data_d = m_w_en_q ? '0 : bus.m_r_data_i;
                    s_ack_d    = grant_q ? 2'b10 : 2'b01;
                    s_err_d    = 1'b0;
                    m_req_d    = 1'b0;
                    state_d    = ST_RESP;
                end else if (timeout_hit) begin
                    s_r_data_d = '0;
                    s_ack_d    = grant_q ? 2'b10 : 2'b01;
                    s_err_d    = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                // Response lasts one cycle; the IDLE that follows keeps m_req low
                last_grant_d = grant_q;
                s_ack_d      = 2'b00;
                s_err_d      = 1'b0;
                s_r_data_d   = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.s_ack_o    = s_ack_q;
    assign bus.s_err_o    = s_err_q;
    assign bus.s_r_data_o = s_r_data_q;
    assign bus.m_req_o    = m_req_q;
    assign bus.m_w_en_o   = m_w_en_q;
    assign bus.m_addr_o   = m_addr_q;
    assign bus.m_w_data_o = m_w_data_q;
endmodule
